// File: rtl/prbs8_pkg.sv
// Shared types and constants for the PRBS8 (x^8+x^4+x^3+x^2+1) receive checker.
package prbs8_pkg;

  localparam int PRBS_W = 8;
  localparam logic [PRBS_W-1:0] TAP_MASK = 8'b0001_1101;

  typedef enum logic [0:0] {
    SEARCH,
    LOCKED
  } chk_state_t;

  // hist[0] is the oldest bit; the XOR of the taps predicts the next line bit.
  function automatic logic prbs8_fb(input logic [PRBS_W-1:0] hist);
    return ^(hist & TAP_MASK);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && (cnt != '1))    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 serial checker with lock detection and error counting.
// Define PRBS8_CHK_BITCNT_EN to build the checked-bit counter; otherwise bit_cnt is tied to 0.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int ER_W = $clog2(UNLOCK_ERRS + 1);
  localparam logic [3:0]      FILL_FULL   = 4'(PRBS_W);
  localparam logic [MR_W-1:0] LOCK_LAST   = MR_W'(LOCK_CNT - 1);
  localparam logic [ER_W-1:0] UNLOCK_LAST = ER_W'(UNLOCK_ERRS - 1);

  logic [PRBS_W-1:0] hist, hist_nxt;
  logic [3:0]        fill, fill_nxt;
  logic [MR_W-1:0]   match_run, match_run_nxt;
  logic [ER_W-1:0]   err_run, err_run_nxt;
  chk_state_t        state, state_nxt;
  logic              err_nxt;
  logic              match;

  // An all-zero history can never precede a valid m-sequence bit, so it never matches.
  assign match = (din == prbs8_fb(hist)) && (hist != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_run <= '0;
      err_run   <= '0;
      state     <= SEARCH;
      err       <= 1'b0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_run <= match_run_nxt;
      err_run   <= err_run_nxt;
      state     <= state_nxt;
      err       <= err_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hist_nxt      = hist;
    fill_nxt      = fill;
    match_run_nxt = match_run;
    err_run_nxt   = err_run;
    state_nxt     = state;
    err_nxt       = 1'b0;
    if (din_vld) begin
      hist_nxt = {din, hist[PRBS_W-1:1]};
      unique case (state)
        SEARCH: begin
          if (fill != FILL_FULL) begin
            fill_nxt = fill + 4'd1;
          end else if (match) begin
            if (match_run == LOCK_LAST) begin
              state_nxt     = LOCKED;
              match_run_nxt = '0;
              err_run_nxt   = '0;
            end else begin
              match_run_nxt = match_run + 1'b1;
            end
          end else begin
            match_run_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            err_run_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            if (err_run == UNLOCK_LAST) begin
              state_nxt     = SEARCH;
              match_run_nxt = '0;
              err_run_nxt   = '0;
            end else begin
              err_run_nxt = err_run + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_nxt),
    .cnt (err_cnt)
  );

`ifdef PRBS8_CHK_BITCNT_EN
  logic bit_inc;
  assign bit_inc = din_vld && (state == LOCKED);

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (bit_inc),
    .cnt (bit_cnt)
  );
`else
  assign bit_cnt = '0;
`endif

endmodule
